io_input_debounce: RTL and testbench
====================================

# io_input_debounce

Fabric BEL that conditions the pad-to-fabric signal delivered by the bidirectional IO BEL. It synchronises the asynchronous pad value into the `UserCLK` domain, applies a configurable glitch filter, and presents a clean level plus single-cycle rise/fall pulses to the switch matrix. Filter length and polarity come from frame configuration bits.

## Interface
- `NoConfigBits`, 5: configuration width. Fixed; do not override.
- `UserCLK`  in  1: fabric user clock. Single clock domain; shared, external.
- `RESET_N`  in  1: reset, synchronous to `UserCLK`, active-low.
- `D`  in  1: raw pad value from the IO BEL output. Asynchronous to `UserCLK`.
- `O`  out  1: filtered, synchronised level.
- `RISE`  out  1: one-cycle pulse when `O` goes 0→1.
- `FALL`  out  1: one-cycle pulse when `O` goes 1→0.
- `ConfigBits`  in  NoConfigBits:
  - [3:0] = N, the qualify length. N=0 is treated as 1.
  - [4] = INV, which inverts `D` before filtering.

## Operation
- Synchroniser: two flops, `s1 <= D`, `s2 <= s1`. Both reset to 0.
- Filter input: `x = s2 ^ INV`.
- Effective length: `Neff = (N==0) ? 1 : N`. A new level must be sampled on `Neff` consecutive cycles before `O` changes.
- FSM states: LOW, QUAL_HI, HIGH, QUAL_LO, with a 4-bit counter `cnt`.
  - LOW, x=1: if `Neff==1`, go to HIGH and pulse RISE. Otherwise go to QUAL_HI with cnt=1.
  - QUAL_HI, x=0: go to LOW with cnt=0. No pulse.
  - QUAL_HI, x=1: if `cnt+1 >= Neff`, go to HIGH, cnt=0, pulse RISE. Otherwise cnt++.
  - HIGH and QUAL_LO: mirror of LOW and QUAL_HI with x inverted. The exit to LOW pulses FALL.
- Output mapping:
  - `O` = 1 in HIGH and QUAL_LO.
  - `O` = 0 in LOW and QUAL_HI.
  - `O`, `RISE` and `FALL` are all registered.
- The comparison uses `>=`. If ConfigBits change mid-qualification to a value at or below `cnt`, the transition completes on the next confirming sample. INV changes are seen as an ordinary input change.
- `cnt` never exceeds 15 and never wraps.
- RISE and FALL are mutually exclusive and never asserted two cycles in a row.

## Timing
- Reset values (RESET_N=0 at a `UserCLK` edge):
  - `s1=s2=0`, state LOW, cnt=0.
  - `O=0`, `RISE=0`, `FALL=0`.
  - Reset takes priority over any pending qualification and discards it.
- After reset, if x=1 the normal qualification runs and a RISE pulse is produced. This is intended behaviour.
- Latency: take `D` captured into `s1` at edge k and then held. `O`, together with `RISE`/`FALL`, updates at edge k+1+Neff.
  - N=1: edge k+2.
  - N=15: edge k+16.
- Glitch rejection: a pulse on x shorter than `Neff` cycles produces no change on `O` and no pulse.
- `RISE`/`FALL` are high for exactly the one cycle in which `O` first shows its new value.
- There is no handshake. Outputs are valid every cycle.

## Structure
- Shared package/header `io_cond_pkg`:
  - FSM state encodings (LOW=2'b00, QUAL_HI=2'b01, HIGH=2'b11, QUAL_LO=2'b10).
  - `NCFG=5`.
  - ConfigBits field offsets (`CFG_N_LSB=0`, `CFG_N_MSB=3`, `CFG_INV=4`).
- Sub-module `io_sync2`: a two-flop synchroniser with synchronous active-low reset to 0. It is reused by other IO-side BELs.
- Top level: `io_sync2`, the FSM plus counter, and the output registers.

## Test plan
- Reset: hold RESET_N=0 for 3 cycles with D=1 → `O=RISE=FALL=0` throughout. After release with N=1, `RISE` is high at edge k+2 only, then `O=1`.
- Latency with N=4: step D 0→1 captured at edge k → `O` rises and `RISE` pulses at edge k+5. Step D 1→0 → `FALL` pulses at the matching edge.
- Glitch rejection with N=4: 3-cycle high pulse on D → `O` stays 0, no RISE. A 4-cycle pulse → RISE pulse, then FALL 4 samples after D returns low.
- N=0 and INV=1:
  - D=0 → `O=1` via one RISE.
  - D toggling every 2 cycles → `O` follows `~D` delayed 3 edges, with alternating pulses.
- Mid-qualify reconfiguration: N=10, D held high for 5 samples, then N changed to 3 → `O` rises on the next sample. Separately, RESET_N=0 during QUAL_HI → state LOW, `cnt=0`, no pulse.

Source files
------------

// File: rtl/io_cond_pkg.sv
// Shared definitions for the fabric-side IO conditioning BELs: debounce FSM
// state encodings and ConfigBits field layout.
package io_cond_pkg;

    localparam int unsigned NCFG      = 5;
    localparam int unsigned CFG_N_LSB = 0;
    localparam int unsigned CFG_N_MSB = 3;
    localparam int unsigned CFG_INV   = 4;

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        QUAL_HI = 2'b01,
        QUAL_LO = 2'b10,
        HIGH    = 2'b11
    } state_t;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; synchronous
// active-low reset clears both stages to 0.
module io_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/io_input_debounce.sv
// Pad-to-fabric conditioner: synchronise D, optionally invert, require Neff
// consecutive samples of a new level before O changes, and pulse RISE/FALL.
module io_input_debounce
    import io_cond_pkg::*;
#(
    parameter int unsigned NoConfigBits = 5
) (
    input  logic                    UserCLK,
    input  logic                    RESET_N,
    input  logic                    D,
    output logic                    O,
    output logic                    RISE,
    output logic                    FALL,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    logic       s2;
    logic       x;
    logic [3:0] n_cfg;
    logic [3:0] neff;
    logic [4:0] cnt_inc;
    logic       qual_done;
    state_t     state;
    logic [3:0] cnt;

    io_sync2 u_sync (
        .clk   (UserCLK),
        .rst_n (RESET_N),
        .d     (D),
        .q     (s2)
    );

    always_comb begin
        n_cfg     = ConfigBits[CFG_N_MSB:CFG_N_LSB];
        neff      = (n_cfg == 4'd0) ? 4'd1 : n_cfg;
        x         = s2 ^ ConfigBits[CFG_INV];
        // Widened so a shrunken Neff mid-qualification still compares correctly
        cnt_inc   = {1'b0, cnt} + 5'd1;
        qual_done = (cnt_inc >= {1'b0, neff});
    end

    always_ff @(posedge UserCLK) begin
        if (!RESET_N) begin
            state <= LOW;
            cnt   <= '0;
            O     <= 1'b0;
            RISE  <= 1'b0;
            FALL  <= 1'b0;
        end else begin
            RISE <= 1'b0;
            FALL <= 1'b0;
            case (state)
                LOW: begin
                    if (x) begin
                        if (neff == 4'd1) begin
                            state <= HIGH;
                            cnt   <= '0;
                            O     <= 1'b1;
                            RISE  <= 1'b1;
                        end else begin
                            state <= QUAL_HI;
                            cnt   <= 4'd1;
                        end
                    end
                end
                QUAL_HI: begin
                    if (!x) begin
                        state <= LOW;
                        cnt   <= '0;
                    end else if (qual_done) begin
                        state <= HIGH;
                        cnt   <= '0;
                        O     <= 1'b1;
                        RISE  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc[3:0];
                    end
                end
                HIGH: begin
                    if (!x) begin
                        if (neff == 4'd1) begin
                            state <= LOW;
                            cnt   <= '0;
                            O     <= 1'b0;
                            FALL  <= 1'b1;
                        end else begin
                            state <= QUAL_LO;
                            cnt   <= 4'd1;
                        end
                    end
                end
                QUAL_LO: begin
                    if (x) begin
                        state <= HIGH;
                        cnt   <= '0;
                    end else if (qual_done) begin
                        state <= LOW;
                        cnt   <= '0;
                        O     <= 1'b0;
                        FALL  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc[3:0];
                    end
                end
                default: begin
                    state <= LOW;
                    cnt   <= '0;
                    O     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce: reset, latency, glitch rejection,
// inversion with N=0, N=15 latency and mid-qualification reconfig/reset.
module tb_io_input_debounce;

    logic       UserCLK;
    logic       RESET_N;
    logic       D;
    logic       O;
    logic       RISE;
    logic       FALL;
    logic [4:0] ConfigBits;

    int vectors;
    int miscompares;

    logic       d_pat   [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [2:0] tog_exp [10] = '{3'b100, 3'b100, 3'b001, 3'b000, 3'b110,
                                 3'b100, 3'b001, 3'b000, 3'b110, 3'b100};

    io_input_debounce #(.NoConfigBits(5)) dut (
        .UserCLK    (UserCLK),
        .RESET_N    (RESET_N),
        .D          (D),
        .O          (O),
        .RISE       (RISE),
        .FALL       (FALL),
        .ConfigBits (ConfigBits)
    );

    initial begin
        UserCLK = 1'b0;
        forever #5 UserCLK = ~UserCLK;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock edge, then check {O,RISE,FALL} 1ns later.
    task automatic step_orf(input string tag, input logic [2:0] exp);
        @(posedge UserCLK);
        #1;
        chk(tag, {5'b0, O, RISE, FALL}, {5'b0, exp});
    endtask

    task automatic run_orf(input int n, input string tag, input logic [2:0] exp);
        for (int i = 0; i < n; i++) step_orf(tag, exp);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset held 3 cycles with D=1, N=1
        RESET_N    = 1'b0;
        D          = 1'b1;
        ConfigBits = 5'b00001;
        run_orf(3, "reset_hold", 3'b000);
        RESET_N = 1'b1;
        run_orf(2, "post_reset_wait", 3'b000);
        step_orf("post_reset_rise", 3'b110);
        step_orf("post_reset_high", 3'b100);

        // N=4 latency, falling then rising
        ConfigBits = 5'b00100;
        D          = 1'b0;
        run_orf(5, "lat4_fall_wait", 3'b100);
        step_orf("lat4_fall", 3'b001);
        step_orf("lat4_low", 3'b000);
        D = 1'b1;
        run_orf(5, "lat4_rise_wait", 3'b000);
        step_orf("lat4_rise", 3'b110);
        step_orf("lat4_high", 3'b100);
        D = 1'b0;
        run_orf(5, "lat4_fall2_wait", 3'b100);
        step_orf("lat4_fall2", 3'b001);
        step_orf("lat4_low2", 3'b000);

        // Glitch rejection at N=4: 3-cycle pulse ignored
        D = 1'b1;
        run_orf(3, "glitch3_hi", 3'b000);
        D = 1'b0;
        run_orf(8, "glitch3_after", 3'b000);

        // 4-cycle pulse accepted
        D = 1'b1;
        run_orf(4, "pulse4_hi", 3'b000);
        D = 1'b0;
        step_orf("pulse4_wait", 3'b000);
        step_orf("pulse4_rise", 3'b110);
        run_orf(3, "pulse4_high", 3'b100);
        step_orf("pulse4_fall", 3'b001);
        step_orf("pulse4_low", 3'b000);

        // N=0 (Neff=1) with INV: D=0 gives O=1
        ConfigBits = 5'b10000;
        step_orf("inv_rise", 3'b110);
        step_orf("inv_high", 3'b100);
        for (int i = 0; i < 10; i++) begin
            D = d_pat[i];
            step_orf("inv_toggle", tog_exp[i]);
        end

        // N=15 latency with INV: D=1 drives x=0
        ConfigBits = 5'b11111;
        D          = 1'b1;
        run_orf(16, "lat15_wait", 3'b100);
        step_orf("lat15_fall", 3'b001);
        step_orf("lat15_low", 3'b000);

        // Mid-qualification shrink of N from 10 to 3
        RESET_N    = 1'b0;
        D          = 1'b1;
        ConfigBits = 5'b01010;
        step_orf("reconf_reset", 3'b000);
        RESET_N = 1'b1;
        run_orf(7, "reconf_qual", 3'b000);
        chk("reconf_cnt", {4'b0, dut.cnt}, 8'd5);
        ConfigBits = 5'b00011;
        step_orf("reconf_rise", 3'b110);
        step_orf("reconf_high", 3'b100);

        // Reset during QUAL_HI discards the qualification
        ConfigBits = 5'b00100;
        D          = 1'b0;
        run_orf(5, "qreset_fall_wait", 3'b100);
        step_orf("qreset_fall", 3'b001);
        step_orf("qreset_low", 3'b000);
        D = 1'b1;
        run_orf(4, "qreset_qual", 3'b000);
        chk("qreset_state_pre", {6'b0, dut.state}, 8'b01);
        chk("qreset_cnt_pre", {4'b0, dut.cnt}, 8'd2);
        RESET_N = 1'b0;
        step_orf("qreset_in_reset", 3'b000);
        chk("qreset_state", {6'b0, dut.state}, 8'b00);
        chk("qreset_cnt", {4'b0, dut.cnt}, 8'd0);
        RESET_N = 1'b1;
        run_orf(5, "qreset_requal", 3'b000);
        step_orf("qreset_rise", 3'b110);
        step_orf("qreset_high", 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
